// File: rtl/wb_pkg.sv
// Shared Wishbone master types: response status, FSM states, bus widths.
// Imported by the master port and its bus interface.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    OK            = 2'd0,
    ERR           = 2'd1,
    RTY_EXHAUSTED = 2'd2,
    TIMEOUT       = 2'd3
  } wb_status_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    BACKOFF = 3'd3,
    RESP    = 3'd4
  } wb_master_state_t;

endpackage

// File: rtl/wb_master_bus_t.sv
// Wishbone classic bus with tags and arbiter grant.
// Field suffixes are from the master's point of view.
interface wb_master_bus_t #(
  parameter int TAGSIZE = 2
);
  import wb_pkg::*;

  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  logic                 wb_lock_o;
  logic [WB_DATA_W-1:0] wb_adr_o;
  logic [WB_DATA_W-1:0] wb_dat_o;
  logic [WB_SEL_W-1:0]  wb_sel_o;
  logic [TAGSIZE-1:0]   wb_tga_o;
  logic [TAGSIZE-1:0]   wb_tgc_o;
  logic [TAGSIZE-1:0]   wb_tgd_o;
  logic [WB_DATA_W-1:0] wb_dat_i;
  logic [TAGSIZE-1:0]   wb_tgd_i;
  logic                 wb_ack_i;
  logic                 wb_err_i;
  logic                 wb_rty_i;
  logic                 wb_gnt_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_lock_o, wb_adr_o, wb_dat_o,
    output wb_sel_o, wb_tga_o, wb_tgc_o,
    output wb_tgd_o,
    input  wb_dat_i, wb_tgd_i, wb_ack_i,
    input  wb_err_i, wb_rty_i, wb_gnt_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_lock_o, wb_adr_o, wb_dat_o,
    input  wb_sel_o, wb_tga_o, wb_tgc_o,
    input  wb_tgd_o,
    output wb_dat_i, wb_tgd_i, wb_ack_i,
    output wb_err_i, wb_rty_i, wb_gnt_i
  );

endinterface

// File: rtl/wb_master_port.sv
// Valid/ready request port to Wishbone classic single transfers,
// with bounded retry on rty and a response timeout.
module wb_master_port #(
  parameter int TAGSIZE   = 2,
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [31:0]        req_adr_i,
  input  logic [31:0]        req_dat_i,
  input  logic [3:0]         req_sel_i,
  input  logic [TAGSIZE-1:0] req_tag_i,
  output logic               rsp_valid_o,
  output logic [31:0]        rsp_dat_o,
  output logic [TAGSIZE-1:0] rsp_tag_o,
  output logic [1:0]         rsp_status_o,
  wb_master_bus_t.master     wb
);
  import wb_pkg::*;

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  wb_master_state_t   state;
  logic [RW-1:0]      retry_cnt;
  logic [TW-1:0]      timeout_cnt;
  logic [TAGSIZE-1:0] tag;
  logic               done;
  wb_status_t         done_st;

  assign req_ready_o  = (state == IDLE);
  assign wb.wb_lock_o = 1'b0;
  assign wb.wb_tga_o  = tag;
  assign wb.wb_tgc_o  = tag;
  assign wb.wb_tgd_o  = tag;

  // Terminal outcome of an XFER cycle; err beats ack beats rty.
  always_comb begin
    done    = 1'b1;
    done_st = wb_pkg::OK;
    if (wb.wb_err_i) begin
      done_st = wb_pkg::ERR;
    end else if (wb.wb_ack_i) begin
      done_st = wb_pkg::OK;
    end else if (wb.wb_rty_i) begin
      done    = (retry_cnt == RMAX);
      done_st = wb_pkg::RTY_EXHAUSTED;
    end else if (TIMEOUT != 0 && timeout_cnt == TLAST) begin
      done_st = wb_pkg::TIMEOUT;
    end else begin
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      retry_cnt    <= '0;
      timeout_cnt  <= '0;
      tag          <= '0;
      wb.wb_cyc_o  <= 1'b0;
      wb.wb_stb_o  <= 1'b0;
      wb.wb_we_o   <= 1'b0;
      wb.wb_adr_o  <= '0;
      wb.wb_dat_o  <= '0;
      wb.wb_sel_o  <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_tag_o    <= '0;
      rsp_status_o <= wb_pkg::OK;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            wb.wb_we_o  <= req_we_i;
            wb.wb_adr_o <= req_adr_i;
            wb.wb_dat_o <= req_dat_i;
            wb.wb_sel_o <= req_sel_i;
            tag         <= req_tag_i;
            wb.wb_cyc_o <= 1'b1;
            retry_cnt   <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (wb.wb_gnt_i) begin
            wb.wb_stb_o <= 1'b1;
            timeout_cnt <= '0;
            state       <= XFER;
          end
        end
        XFER: begin
          if (done) begin
            wb.wb_cyc_o  <= 1'b0;
            wb.wb_stb_o  <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= done_st;
            state        <= RESP;
            if (!wb.wb_err_i && wb.wb_ack_i) begin
              rsp_dat_o <= wb.wb_dat_i;
              rsp_tag_o <= wb.wb_tgd_i;
            end
          end else if (wb.wb_rty_i) begin
            retry_cnt   <= retry_cnt + 1'b1;
            wb.wb_stb_o <= 1'b0;
            state       <= BACKOFF;
          end else if (timeout_cnt != '1) begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        BACKOFF: state <= REQ;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_port.sv
// Randomized bench for wb_master_port against a transaction-level
// timeline model with a programmable Wishbone slave.
module tb_wb_master_port;

  localparam int TS = 2;
  localparam int MR = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_adr;
  logic [31:0]   req_dat;
  logic [3:0]    req_sel;
  logic [TS-1:0] req_tag;
  logic          rsp_valid;
  logic [31:0]   rsp_dat;
  logic [TS-1:0] rsp_tag;
  logic [1:0]    rsp_status;

  int vectors = 0;
  int miscompares = 0;

  wb_master_bus_t #(.TAGSIZE(TS)) bus ();

  wb_master_port #(
    .TAGSIZE(TS), .MAX_RETRY(MR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_adr_i(req_adr),
    .req_dat_i(req_dat), .req_sel_i(req_sel),
    .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat),
    .rsp_tag_o(rsp_tag), .rsp_status_o(rsp_status),
    .wb(bus)
  );

  // slave plan: grant after gnt_delay cyc cycles, rty_n retries,
  // then fin: 0 none, 1 ack, 2 err, 3 ack+err, 4 ack+rty
  int gnt_delay = 0;
  int rty_n = 0;
  int fin = 1;
  logic [31:0]   s_dat = '0;
  logic [TS-1:0] s_tgd = '0;
  int cyc_age = 0;
  int rty_given = 0;

  always_ff @(posedge clk) begin
    if (!bus.wb_cyc_o) begin
      cyc_age   <= 0;
      rty_given <= 0;
    end else begin
      cyc_age <= cyc_age + 1;
      if (bus.wb_stb_o && bus.wb_rty_i)
        rty_given <= rty_given + 1;
    end
  end

  always_comb begin
    bus.wb_gnt_i = (cyc_age >= gnt_delay);
    bus.wb_dat_i = s_dat;
    bus.wb_tgd_i = s_tgd;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    if (bus.wb_cyc_o && bus.wb_stb_o) begin
      if (rty_given < rty_n) begin
        bus.wb_rty_i = 1'b1;
      end else begin
        bus.wb_ack_i = (fin == 1 || fin == 3 || fin == 4);
        bus.wb_err_i = (fin == 2 || fin == 3);
        bus.wb_rty_i = (fin == 4);
      end
    end
  end

  // Expected status, response cycle (accept = 0) and stb-high count.
  function automatic void model(input int d, input int r, input int f,
                                output int st, output int lat,
                                output int stbc);
    int fl;
    if (r > MR) begin
      st = 2; lat = d + 2 + 3 * MR + 1; stbc = MR + 1;
      return;
    end
    if (f == 0) begin st = 3; fl = TO; end
    else if (f == 2 || f == 3) begin st = 1; fl = 1; end
    else begin st = 0; fl = 1; end
    lat = d + 2 + 3 * r + fl;
    stbc = r + fl;
  endfunction

  task automatic run_xfer(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input logic [TS-1:0] tag, input int d,
                          input int r, input int f,
                          input logic [31:0] sd, input logic [TS-1:0] stg,
                          input string nm);
    int st, lat, stbc, k, cycc, stbn;
    bit got, held;
    logic cyc_at, stb_at;
    model(d, r, f, st, lat, stbc);
    gnt_delay = d; rty_n = r; fin = f; s_dat = sd; s_tgd = stg;
    @(negedge clk);
    for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_adr = adr;
    req_dat = dat; req_sel = sel; req_tag = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_adr = ~adr; req_dat = ~dat; req_we = ~we;
    got = 0; cycc = 0; stbn = 0; held = 1; k = 0;
    cyc_at = 1'b0; stb_at = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; k = i;
        cyc_at = bus.wb_cyc_o; stb_at = bus.wb_stb_o;
        break;
      end
      if (bus.wb_cyc_o) begin
        cycc++;
        if (bus.wb_adr_o !== adr || bus.wb_dat_o !== dat ||
            bus.wb_sel_o !== sel || bus.wb_we_o !== we ||
            bus.wb_tga_o !== tag || bus.wb_tgc_o !== tag ||
            bus.wb_tgd_o !== tag || bus.wb_lock_o !== 1'b0)
          held = 0;
      end
      if (bus.wb_stb_o) stbn++;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s rsp_wait: no rsp_valid in 200 cycles", nm);
      return;
    end
    vectors++;
    if (k !== lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", nm, k, lat);
    end
    vectors++;
    if (rsp_status !== st[1:0]) begin
      miscompares++;
      $display("FAIL %s status: got %0d want %0d", nm, rsp_status, st);
    end
    if (st == 0) begin
      vectors++;
      if (rsp_dat !== sd || rsp_tag !== stg) begin
        miscompares++;
        $display("FAIL %s rdata: got %h/%0d want %h/%0d",
                 nm, rsp_dat, rsp_tag, sd, stg);
      end
    end
    vectors++;
    if (cyc_at !== 1'b0 || stb_at !== 1'b0) begin
      miscompares++;
      $display("FAIL %s resp_bus: cyc %b stb %b want 0 0",
               nm, cyc_at, stb_at);
    end
    vectors++;
    if (cycc !== lat - 1) begin
      miscompares++;
      $display("FAIL %s cyc_len: got %0d want %0d", nm, cycc, lat - 1);
    end
    vectors++;
    if (stbn !== stbc) begin
      miscompares++;
      $display("FAIL %s stb_len: got %0d want %0d", nm, stbn, stbc);
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL %s hold: outputs changed, want stable %h %h %h",
               nm, adr, dat, sel);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pulse: rsp_valid %b want 0", nm, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_adr = '0; req_dat = '0; req_sel = '0; req_tag = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || bus.wb_cyc_o !== 1'b0 ||
        bus.wb_stb_o !== 1'b0 || bus.wb_we_o !== 1'b0 ||
        bus.wb_lock_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: rdy %b cyc %b stb %b we %b lk %b want 10000",
               req_ready, bus.wb_cyc_o, bus.wb_stb_o,
               bus.wb_we_o, bus.wb_lock_o);
    end
    vectors++;
    if (bus.wb_adr_o !== '0 || bus.wb_dat_o !== '0 ||
        bus.wb_sel_o !== '0 || bus.wb_tga_o !== '0 ||
        rsp_valid !== 1'b0 || rsp_dat !== '0 ||
        rsp_tag !== '0 || rsp_status !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_data: adr %h dat %h rsp %b/%h/%0d want zeros",
               bus.wb_adr_o, bus.wb_dat_o, rsp_valid, rsp_dat, rsp_status);
    end
  endtask

  task automatic test_directed();
    run_xfer(0, 32'h0000_1000, 32'h0, 4'hF, 2'b01, 0, 0, 1,
             32'hDEAD_BEEF, 2'b10, "read_zero_wait");
    run_xfer(1, 32'h40, 32'h1234_5678, 4'b0011, 2'b11, 5, 0, 1,
             32'h0BAD_F00D, 2'b01, "write_gnt_delay");
    run_xfer(0, 32'h80, 32'h0, 4'hF, 2'b00, 0, 3, 1,
             32'hCAFE_0001, 2'b11, "rty3_ack");
    run_xfer(0, 32'h84, 32'h0, 4'hF, 2'b00, 1, 5, 1,
             32'hCAFE_0002, 2'b01, "rty5_exhaust");
    run_xfer(0, 32'h88, 32'h0, 4'hF, 2'b10, 0, 0, 0,
             32'h0, 2'b00, "timeout");
    run_xfer(0, 32'h8C, 32'h0, 4'hF, 2'b01, 0, 0, 3,
             32'h5555_AAAA, 2'b11, "ack_err");
    run_xfer(1, 32'h90, 32'h7777_0000, 4'h1, 2'b01, 0, 0, 4,
             32'h1357_9BDF, 2'b10, "ack_rty");
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic rdy;
    gnt_delay = 0; rty_n = 0; fin = 1; s_dat = 32'h2468_ACE0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h100;
    req_sel = 4'hF; req_tag = 2'b01;
    for (int c = 0; c < 40 && acc.size() < 3; c++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) acc.push_back(c);
    end
    #1 req_valid = 1'b0;
    vectors++;
    if (acc.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d accepts want 3", acc.size());
    end else begin
      vectors++;
      if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
        miscompares++;
        $display("FAIL b2b_gap: got %0d,%0d want 4,4",
                 acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    gnt_delay = 0; rty_n = 0; fin = 0;
    @(negedge clk);
    for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h200;
    req_dat = 32'hFFFF_0000; req_sel = 4'hF; req_tag = 2'b11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.wb_stb_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: stb %b want 1", bus.wb_stb_o);
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_drop: cyc %b stb %b want 0 0",
               bus.wb_cyc_o, bus.wb_stb_o);
    end
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    rstn = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL midrst_rsp: rsp_valid seen want none");
    end
    run_xfer(0, 32'h204, 32'h0, 4'hF, 2'b10, 0, 0, 1,
             32'hA5A5_5A5A, 2'b01, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom,
               4'($urandom), 2'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 4)), $urandom, 2'($urandom),
               $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
